// File: rtl/mem_stage_access.sv
`default_nettype none
// ============================================================================
// mem_stage_access : MEM stage and MEM/WB register with a req/ack data port,
//                    misalignment trap and wait-cycle timeout.
// Revision 1.0
// ============================================================================
module mem_stage_access #(
   parameter int DATA_W  = 32,
   parameter int RD_W    = 5,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_In,
   input  logic [DATA_W-1:0] PC_In,
   input  logic [DATA_W-1:0] Rt_In,
   input  logic [RD_W-1:0]   rd_In,
   input  logic [DATA_W-1:0] ALUResult_In,
   input  logic              mem_read_In,
   input  logic              mem_write_In,
   input  logic              reg_write_In,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              valid_Out,
   output logic [DATA_W-1:0] PC_Out,
   output logic [RD_W-1:0]   rd_Out,
   output logic [DATA_W-1:0] ALUResult_Out,
   output logic [DATA_W-1:0] MemData_Out,
   output logic              reg_write_Out,
   output logic              err_Out
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit             TO_EN    = (TIMEOUT != 0);

   logic [0:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;

   // Fields of the instruction whose memory access is in flight
   logic [DATA_W-1:0] r_pc_l;
   logic [RD_W-1:0]   r_rd_l;
   logic [DATA_W-1:0] r_alu_l;
   logic              r_rw_l;

   logic              r_req;
   logic              r_we;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic              r_valid;
   logic [DATA_W-1:0] r_pc;
   logic [RD_W-1:0]   r_rd;
   logic [DATA_W-1:0] r_alu;
   logic [DATA_W-1:0] r_md;
   logic              r_rw;
   logic              r_err;

   logic w_is_mem;
   logic w_aligned;
   logic w_abort;

   assign w_is_mem  = valid_In & (mem_read_In | mem_write_In);
   assign w_aligned = (ALUResult_In[1:0] == 2'b00);
   assign w_abort   = TO_EN && (r_state == S_WAIT) && !dmem_ack && (r_cnt == CNT_LAST);

   // On the abort cycle EX/MEM is released so the failed access is retired, not retried
   assign stall = rst_n & (((r_state == S_IDLE) & w_is_mem & w_aligned) |
                           ((r_state == S_WAIT) & ~dmem_ack & ~w_abort));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pc_l  <= '0;
         r_rd_l  <= '0;
         r_alu_l <= '0;
         r_rw_l  <= 1'b0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_rd    <= '0;
         r_alu   <= '0;
         r_md    <= '0;
         r_rw    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!valid_In) begin
                  r_valid <= 1'b0;
               end else if (!w_is_mem) begin
                  r_valid <= 1'b1;
                  r_pc    <= PC_In;
                  r_rd    <= rd_In;
                  r_alu   <= ALUResult_In;
                  r_md    <= '0;
                  r_rw    <= reg_write_In;
                  r_err   <= 1'b0;
               end else if (!w_aligned) begin
                  r_valid <= 1'b1;
                  r_pc    <= PC_In;
                  r_rd    <= rd_In;
                  r_alu   <= ALUResult_In;
                  r_md    <= '0;
                  r_rw    <= 1'b0;
                  r_err   <= 1'b1;
               end else begin
                  r_pc_l  <= PC_In;
                  r_rd_l  <= rd_In;
                  r_alu_l <= ALUResult_In;
                  r_rw_l  <= reg_write_In;
                  // A load takes priority when both read and write are flagged
                  r_we    <= mem_write_In & ~mem_read_In;
                  r_req   <= 1'b1;
                  r_addr  <= ALUResult_In;
                  r_wdata <= Rt_In;
                  r_valid <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dmem_ack) begin
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
                  r_pc    <= r_pc_l;
                  r_rd    <= r_rd_l;
                  r_alu   <= r_alu_l;
                  r_md    <= r_we ? '0 : dmem_rdata;
                  r_rw    <= r_rw_l;
                  r_err   <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_abort) begin
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
                  r_pc    <= r_pc_l;
                  r_rd    <= r_rd_l;
                  r_alu   <= r_alu_l;
                  r_md    <= '0;
                  r_rw    <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_valid <= 1'b0;
                  if (r_cnt != {CNT_W{1'b1}}) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign dmem_req      = r_req;
   assign dmem_we       = r_we;
   assign dmem_addr     = r_addr;
   assign dmem_wdata    = r_wdata;
   assign valid_Out     = r_valid;
   assign PC_Out        = r_pc;
   assign rd_Out        = r_rd;
   assign ALUResult_Out = r_alu;
   assign MemData_Out   = r_md;
   assign reg_write_Out = r_rw;
   assign err_Out       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_access : vector table, directed sequences and random traffic
//                       against a transaction-level model of the MEM stage.
// Revision 1.0
// ============================================================================
module tb_mem_stage_access;

   localparam int TO = 4;
   localparam int NV = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_In, mem_read_In, mem_write_In, reg_write_In;
   logic [31:0] PC_In, Rt_In, ALUResult_In;
   logic [4:0]  rd_In;
   logic        stall, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        valid_Out, reg_write_Out, err_Out;
   logic [31:0] PC_Out, ALUResult_Out, MemData_Out;
   logic [4:0]  rd_Out;

   always #5 clk = ~clk;

   mem_stage_access #(.DATA_W(32), .RD_W(5), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .valid_In(valid_In), .PC_In(PC_In), .Rt_In(Rt_In),
      .rd_In(rd_In), .ALUResult_In(ALUResult_In), .mem_read_In(mem_read_In),
      .mem_write_In(mem_write_In), .reg_write_In(reg_write_In), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .valid_Out(valid_Out), .PC_Out(PC_Out), .rd_Out(rd_Out),
      .ALUResult_Out(ALUResult_Out), .MemData_Out(MemData_Out),
      .reg_write_Out(reg_write_Out), .err_Out(err_Out)
   );

   typedef struct {
      logic valid; logic [31:0] pc; logic [31:0] rt; logic [4:0] rd; logic [31:0] alu;
      logic mr; logic mw; logic rw; int dly; logic [31:0] rdata;
   } instr_t;

   typedef struct {
      logic valid; logic [31:0] pc; logic [4:0] rd; logic [31:0] alu;
      logic [31:0] md; logic rw; logic err;
   } res_t;

   typedef struct { instr_t in; logic ack; res_t exp; } vec_t;

   int     n_vec = 0;
   int     n_err = 0;
   res_t   last;
   vec_t   tv [NV];

   function automatic instr_t mk_in(input logic v, input logic [31:0] pc, input logic [31:0] rt,
                                    input logic [4:0] rd, input logic [31:0] alu, input logic mr,
                                    input logic mw, input logic rw, input int dly,
                                    input logic [31:0] rdata);
      instr_t t;
      t.valid = v; t.pc = pc; t.rt = rt; t.rd = rd; t.alu = alu;
      t.mr = mr; t.mw = mw; t.rw = rw; t.dly = dly; t.rdata = rdata;
      return t;
   endfunction

   function automatic res_t mk_res(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                                   input logic [31:0] alu, input logic [31:0] md,
                                   input logic rw, input logic err);
      res_t r;
      r.valid = v; r.pc = pc; r.rd = rd; r.alu = alu; r.md = md; r.rw = rw; r.err = err;
      return r;
   endfunction

   // Instruction-level reference: what MEM/WB holds once this instruction retires
   function automatic res_t model(input instr_t in, input res_t prev);
      res_t r;
      r = prev;
      if (!in.valid) begin
         r.valid = 1'b0;
         return r;
      end
      r = mk_res(1'b1, in.pc, in.rd, in.alu, 32'h0, in.rw, 1'b0);
      if (in.mr || in.mw) begin
         if ((in.alu % 4) != 0 || (in.dly + 1) > TO) begin
            r.err = 1'b1;
            r.rw  = 1'b0;
         end else if (in.mr) begin
            r.md = in.rdata;
         end
      end
      return r;
   endfunction

   function automatic bit goes_to_mem(input instr_t in);
      return in.valid && (in.mr || in.mw) && ((in.alu % 4) == 0);
   endfunction

   function automatic int n_cycles(input instr_t in);
      if (!goes_to_mem(in)) return 1;
      return 1 + (((in.dly + 1) < TO) ? (in.dly + 1) : TO);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_res(input string tag, input res_t e);
      chk({tag, ".valid"}, valid_Out, e.valid);
      chk({tag, ".pc"}, PC_Out, e.pc);
      chk({tag, ".rd"}, rd_Out, e.rd);
      chk({tag, ".alu"}, ALUResult_Out, e.alu);
      chk({tag, ".md"}, MemData_Out, e.md);
      chk({tag, ".rw"}, reg_write_Out, e.rw);
      chk({tag, ".err"}, err_Out, e.err);
   endtask

   task automatic drive(input instr_t in);
      valid_In = in.valid; PC_In = in.pc; Rt_In = in.rt; rd_In = in.rd;
      ALUResult_In = in.alu; mem_read_In = in.mr; mem_write_In = in.mw; reg_write_In = in.rw;
   endtask

   // Presents one instruction, plays the memory side, holds it while stalled,
   // then checks the retired result. Entered and left at posedge+1.
   task automatic run_instr(input string tag, input instr_t in);
      int   total;
      int   rcnt;
      res_t e;
      total = n_cycles(in);
      rcnt  = 0;
      drive(in);
      for (int cyc = 1; cyc <= total; cyc++) begin
         if (dmem_req) rcnt++;
         dmem_ack   = dmem_req && (rcnt == in.dly + 1);
         dmem_rdata = in.rdata;
         @(negedge clk);
         chk({tag, ".stall"}, stall, (cyc < total));
         chk({tag, ".req"}, dmem_req, (goes_to_mem(in) && cyc > 1));
         if (goes_to_mem(in) && cyc > 1) begin
            chk({tag, ".we"}, dmem_we, !in.mr);
            chk({tag, ".addr"}, dmem_addr, in.alu);
            chk({tag, ".wdata"}, dmem_wdata, in.rt);
         end
         @(posedge clk);
         #1;
         dmem_ack = 1'b0;
         if (cyc < total) chk({tag, ".wait_valid"}, valid_Out, 1'b0);
      end
      e = model(in, last);
      chk_res(tag, e);
      chk({tag, ".req_done"}, dmem_req, 1'b0);
      last = e;
   endtask

   function automatic instr_t rnd_instr();
      instr_t t;
      int k;
      k = $urandom_range(0, 99);
      t = mk_in(k >= 12, $urandom, $urandom, 5'($urandom), $urandom, 1'b0, 1'b0,
                1'($urandom), $urandom_range(0, 6), $urandom);
      if (k >= 40) begin
         t.mr = 1'($urandom);
         t.mw = t.mr ? 1'($urandom) : 1'b1;
         if (k < 90) t.alu[1:0] = 2'b00;
      end
      return t;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, ".stall"}, stall, 1'b0);
      chk({tag, ".req"}, dmem_req, 1'b0);
      chk({tag, ".we"}, dmem_we, 1'b0);
      chk({tag, ".addr"}, dmem_addr, 32'h0);
      chk({tag, ".wdata"}, dmem_wdata, 32'h0);
      chk_res(tag, mk_res(1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0));
   endtask

   initial begin
      tv[0] = '{in: mk_in(1, 32'h100, 32'h5, 5'd3, 32'h10, 0, 0, 1, 0, 0), ack: 1'b0,
                exp: mk_res(1, 32'h100, 5'd3, 32'h10, 0, 1, 0)};
      tv[1] = '{in: mk_in(0, 32'h999, 32'h0, 5'd7, 32'h77, 0, 0, 1, 0, 0), ack: 1'b0,
                exp: mk_res(0, 32'h100, 5'd3, 32'h10, 0, 1, 0)};
      tv[2] = '{in: mk_in(1, 32'h104, 32'h0, 5'd4, 32'h42, 1, 0, 1, 0, 0), ack: 1'b0,
                exp: mk_res(1, 32'h104, 5'd4, 32'h42, 0, 0, 1)};
      tv[3] = '{in: mk_in(0, 32'h888, 32'h0, 5'd2, 32'h40, 1, 0, 1, 0, 0), ack: 1'b0,
                exp: mk_res(0, 32'h104, 5'd4, 32'h42, 0, 0, 1)};
      tv[4] = '{in: mk_in(1, 32'h108, 32'hABCD, 5'd0, 32'h45, 0, 1, 0, 0, 0), ack: 1'b0,
                exp: mk_res(1, 32'h108, 5'd0, 32'h45, 0, 0, 1)};
      tv[5] = '{in: mk_in(1, 32'h10C, 32'h0, 5'd9, 32'h43, 1, 1, 1, 0, 0), ack: 1'b0,
                exp: mk_res(1, 32'h10C, 5'd9, 32'h43, 0, 0, 1)};
      tv[6] = '{in: mk_in(1, 32'h110, 32'h0, 5'd31, 32'hFFFFFFFC, 0, 0, 0, 0, 0), ack: 1'b0,
                exp: mk_res(1, 32'h110, 5'd31, 32'hFFFFFFFC, 0, 0, 0)};
      tv[7] = '{in: mk_in(1, 32'h114, 32'h0, 5'd5, 32'h0, 0, 0, 1, 0, 0), ack: 1'b1,
                exp: mk_res(1, 32'h114, 5'd5, 32'h0, 0, 1, 0)};

      drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      last = mk_res(0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < NV; i++) begin
         drive(tv[i].in);
         dmem_ack   = tv[i].ack;
         dmem_rdata = 32'hA5A5A5A5;
         @(negedge clk);
         chk($sformatf("v%0d.stall", i), stall, 1'b0);
         chk($sformatf("v%0d.req", i), dmem_req, 1'b0);
         @(posedge clk);
         #1;
         dmem_ack = 1'b0;
         chk_res($sformatf("v%0d", i), tv[i].exp);
         last = tv[i].exp;
      end

      run_instr("load3", mk_in(1, 32'h200, 32'h0, 5'd8, 32'h40, 1, 0, 1, 3, 32'hDEADBEEF));
      chk("load3.data", MemData_Out, 32'hDEADBEEF);
      chk("load3.rw", reg_write_Out, 1'b1);
      run_instr("store0", mk_in(1, 32'h204, 32'h1234, 5'd0, 32'h44, 0, 1, 0, 0, 32'hFFFF0000));
      chk("store0.md", MemData_Out, 32'h0);
      run_instr("abort", mk_in(1, 32'h208, 32'h0, 5'd9, 32'h48, 1, 0, 1, 100, 32'h5555AAAA));
      chk("abort.err", err_Out, 1'b1);
      run_instr("edge3", mk_in(1, 32'h20C, 32'h0, 5'd1, 32'h4C, 1, 0, 1, TO - 1, 32'h0BADF00D));
      run_instr("bub", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < 300; i++) run_instr($sformatf("rnd%0d", i), rnd_instr());

      // Asynchronous reset while a load is waiting on memory
      drive(mk_in(1, 32'h300, 32'h0, 5'd6, 32'h50, 1, 0, 1, 20, 32'h0));
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("rstwait.req_before", dmem_req, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("rstwait");
      drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      last = mk_res(0, 0, 0, 0, 0, 0, 0);
      run_instr("post.load", mk_in(1, 32'h400, 32'h0, 5'd12, 32'h80, 1, 0, 1, 1, 32'hCAFEF00D));
      run_instr("post.add", mk_in(1, 32'h404, 32'h0, 5'd13, 32'h99, 0, 0, 1, 0, 32'h0));
      run_instr("post.bub", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: got timeout, want completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
